// File: rtl/pattern_detector_n.sv
// rtl/pattern_detector_n.sv - serial N-bit pattern detector with saturating match counter
module pattern_detector_n #(
    parameter int unsigned  N       = 3,
    parameter logic [N-1:0] PATTERN = N'(3'b111),
    parameter int unsigned  OVERLAP = 1,
    parameter int unsigned  CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic                     din,
    input  logic                     clear,
    output logic                     match,
    output logic [CNT_W-1:0]         match_count,
    output logic                     count_sat,
    output logic [$clog2(N+1)-1:0]   fill
);

    localparam int unsigned      FW      = $clog2(N + 1);
    localparam logic [FW-1:0]    FULL    = FW'(N);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     hist_q,  hist_d;
    logic [FW-1:0]    fill_q,  fill_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             match_q, match_d;
    logic             sat_q,   sat_d;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        match_d = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (sample_en) begin
            hist_d = {hist_q[N-2:0], din};
            fill_d = (fill_q == FULL) ? FULL : fill_q + FW'(1);
            // The match decision looks at the post-shift window, including this sample.
            if ((fill_d == FULL) && (hist_d == PATTERN)) begin
                match_d = 1'b1;
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (OVERLAP == 0) begin
                    fill_d = '0;
                end
            end
        end
        sat_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            match_q <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            match_q <= match_d;
            sat_q   <= sat_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign count_sat   = sat_q;
    assign fill        = fill_q;

endmodule

// File: tb/tb_pattern_detector_n.sv
// tb/tb_pattern_detector_n.sv - randomized and directed bench for pattern_detector_n
module tb_pattern_detector_n;

    localparam int NDUT = 6;
    localparam int MN[NDUT] = '{3, 3, 3, 3, 3, 5};
    localparam int MP[NDUT] = '{7, 5, 5, 7, 7, 22};
    localparam int MO[NDUT] = '{1, 1, 0, 0, 1, 1};
    localparam int MC[NDUT] = '{8, 8, 8, 8, 2, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic sample_en = 1'b0;
    logic din = 1'b0;
    logic clear = 1'b0;

    logic       m [NDUT];
    logic       s [NDUT];
    logic [7:0] c0, c1, c2, c3;
    logic [1:0] c4;
    logic [3:0] c5;
    logic [1:0] f0, f1, f2, f3, f4;
    logic [2:0] f5;
    int cnt_o  [NDUT];
    int fill_o [NDUT];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pattern_detector_n u0 (.clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
                           .match(m[0]), .match_count(c0), .count_sat(s[0]), .fill(f0));
    pattern_detector_n #(.N(3), .PATTERN(3'b101), .OVERLAP(1), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
        .match(m[1]), .match_count(c1), .count_sat(s[1]), .fill(f1));
    pattern_detector_n #(.N(3), .PATTERN(3'b101), .OVERLAP(0), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
        .match(m[2]), .match_count(c2), .count_sat(s[2]), .fill(f2));
    pattern_detector_n #(.N(3), .PATTERN(3'b111), .OVERLAP(0), .CNT_W(8)) u3 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
        .match(m[3]), .match_count(c3), .count_sat(s[3]), .fill(f3));
    pattern_detector_n #(.N(3), .PATTERN(3'b111), .OVERLAP(1), .CNT_W(2)) u4 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
        .match(m[4]), .match_count(c4), .count_sat(s[4]), .fill(f4));
    pattern_detector_n #(.N(5), .PATTERN(5'b10110), .OVERLAP(1), .CNT_W(4)) u5 (
        .clk(clk), .rst_n(rst_n), .sample_en(sample_en), .din(din), .clear(clear),
        .match(m[5]), .match_count(c5), .count_sat(s[5]), .fill(f5));

    assign cnt_o[0] = int'(c0);
    assign cnt_o[1] = int'(c1);
    assign cnt_o[2] = int'(c2);
    assign cnt_o[3] = int'(c3);
    assign cnt_o[4] = int'(c4);
    assign cnt_o[5] = int'(c5);
    assign fill_o[0] = int'(f0);
    assign fill_o[1] = int'(f1);
    assign fill_o[2] = int'(f2);
    assign fill_o[3] = int'(f3);
    assign fill_o[4] = int'(f4);
    assign fill_o[5] = int'(f5);

    // Reference: full log of samples since reset/clear; a match is the last N logged
    // samples (after the current window start) spelling PATTERN oldest-first.
    bit lg [NDUT][0:8191];
    int len [NDUT];
    int wstart [NDUT];
    int mcnt [NDUT];
    bit mmatch [NDUT];

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            len[k] = 0; wstart[k] = 0; mcnt[k] = 0; mmatch[k] = 1'b0;
        end
    endfunction

    function automatic int cmax(input int k);
        return (1 << MC[k]) - 1;
    endfunction

    function automatic int exp_fill(input int k);
        int a;
        a = len[k] - wstart[k];
        return (a > MN[k]) ? MN[k] : a;
    endfunction

    function automatic void model_step(input bit en, input bit d, input bit clr);
        bit hit;
        for (int k = 0; k < NDUT; k++) begin
            mmatch[k] = 1'b0;
            if (clr) begin
                len[k] = 0; wstart[k] = 0; mcnt[k] = 0;
            end else if (en) begin
                lg[k][len[k]] = d;
                len[k]++;
                if (len[k] - wstart[k] >= MN[k]) begin
                    hit = 1'b1;
                    for (int j = 0; j < MN[k]; j++)
                        if (lg[k][len[k] - MN[k] + j] != bit'((MP[k] >> (MN[k] - 1 - j)) & 1))
                            hit = 1'b0;
                    if (hit) begin
                        mmatch[k] = 1'b1;
                        if (mcnt[k] < cmax(k)) mcnt[k]++;
                        if (MO[k] == 0) wstart[k] = len[k];
                    end
                end
            end
        end
    endfunction

    task automatic step(input bit en, input bit d, input bit clr);
        sample_en = en; din = d; clear = clr;
        @(posedge clk);
        model_step(en, d, clr);
        #1;
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (m[k] !== 1'b0 || s[k] !== 1'b0 || cnt_o[k] !== 0 || fill_o[k] !== 0) begin
                failures++;
                $display("FAIL reset_async dut%0d got m=%0b sat=%0b cnt=%0d fill=%0d want all 0", k, m[k], s[k], cnt_o[k], fill_o[k]);
            end
        end
        sample_en = 1'b1; din = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NDUT; k++) begin
            checks++;
            if (m[k] !== 1'b0 || cnt_o[k] !== 0 || fill_o[k] !== 0) begin
                failures++;
                $display("FAIL reset_held dut%0d got m=%0b cnt=%0d fill=%0d want all 0", k, m[k], cnt_o[k], fill_o[k]);
            end
        end
        rst_n = 1'b1;
        model_reset();
        step(1, 1, 0);
        checks++;
        if (fill_o[0] !== 1) begin
            failures++;
            $display("FAIL first_edge_after_reset got fill=%0d want 1", fill_o[0]);
        end
    endtask

    task automatic test_default_seq();
        bit seq [6] = '{1, 1, 1, 1, 0, 1};
        bit exp [6] = '{0, 0, 1, 1, 0, 0};
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, seq[i], 0);
            checks++;
            if (m[0] !== exp[i]) begin
                failures++;
                $display("FAIL default_match sample %0d got %0b want %0b", i + 1, m[0], exp[i]);
            end
        end
        checks++;
        if (cnt_o[0] !== 2) begin
            failures++;
            $display("FAIL default_count got %0d want 2", cnt_o[0]);
        end
        step(0, 1, 0);
        checks++;
        if (m[0] !== 1'b0 || cnt_o[0] !== 2 || fill_o[0] !== 3) begin
            failures++;
            $display("FAIL idle_hold got m=%0b cnt=%0d fill=%0d want 0/2/3", m[0], cnt_o[0], fill_o[0]);
        end
    endtask

    task automatic test_overlap_101();
        bit seq [5] = '{1, 0, 1, 0, 1};
        bit e1 [5] = '{0, 0, 1, 0, 1};
        bit e2 [5] = '{0, 0, 1, 0, 0};
        step(0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, seq[i], 0);
            checks++;
            if (m[1] !== e1[i] || m[2] !== e2[i]) begin
                failures++;
                $display("FAIL p101_match sample %0d got ov=%0b nov=%0b want %0b/%0b", i + 1, m[1], m[2], e1[i], e2[i]);
            end
        end
        checks++;
        if (cnt_o[1] !== 2 || cnt_o[2] !== 1) begin
            failures++;
            $display("FAIL p101_count got ov=%0d nov=%0d want 2/1", cnt_o[1], cnt_o[2]);
        end
    endtask

    task automatic test_nonoverlap_fill();
        int ef [6] = '{1, 2, 0, 1, 2, 0};
        bit em [6] = '{0, 0, 1, 0, 0, 1};
        step(0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            step(1, 1, 0);
            checks++;
            if (fill_o[3] !== ef[i] || m[3] !== em[i]) begin
                failures++;
                $display("FAIL nov_fill sample %0d got fill=%0d m=%0b want %0d/%0b", i + 1, fill_o[3], m[3], ef[i], em[i]);
            end
        end
    endtask

    task automatic test_saturate();
        int ec [7] = '{0, 0, 1, 2, 3, 3, 3};
        bit es [7] = '{0, 0, 0, 0, 1, 1, 1};
        bit em [7] = '{0, 0, 1, 1, 1, 1, 1};
        step(0, 0, 1);
        for (int i = 0; i < 7; i++) begin
            step(1, 1, 0);
            checks++;
            if (cnt_o[4] !== ec[i] || s[4] !== es[i] || m[4] !== em[i]) begin
                failures++;
                $display("FAIL saturate sample %0d got cnt=%0d sat=%0b m=%0b want %0d/%0b/%0b",
                         i + 1, cnt_o[4], s[4], m[4], ec[i], es[i], em[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 1);
        step(1, 1, 0);
        step(1, 1, 0);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        step(1, 1, 0);
        checks++;
        if (m[0] !== 1'b0 || fill_o[0] !== 1) begin
            failures++;
            $display("FAIL reset_mid_first got m=%0b fill=%0d want 0/1", m[0], fill_o[0]);
        end
        step(1, 1, 0);
        step(1, 1, 0);
        checks++;
        if (m[0] !== 1'b1 || cnt_o[0] !== 1) begin
            failures++;
            $display("FAIL reset_mid_match got m=%0b cnt=%0d want 1/1", m[0], cnt_o[0]);
        end
        step(1, 1, 1);
        checks++;
        if (m[0] !== 1'b0 || fill_o[0] !== 0 || cnt_o[0] !== 0) begin
            failures++;
            $display("FAIL clear_priority got m=%0b fill=%0d cnt=%0d want 0/0/0", m[0], fill_o[0], cnt_o[0]);
        end
    endtask

    task automatic test_gap_vs_back_to_back();
        bit seq [24];
        bit tm [2][24];
        int tc [2][24];
        int ids [2] = '{0, 5};
        for (int i = 0; i < 24; i++) seq[i] = 1'($urandom_range(0, 1));
        step(0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            step(1, seq[i], 0);
            for (int j = 0; j < 2; j++) begin
                tm[j][i] = m[ids[j]];
                tc[j][i] = cnt_o[ids[j]];
                checks++;
                if (m[ids[j]] !== mmatch[ids[j]] || cnt_o[ids[j]] !== mcnt[ids[j]]) begin
                    failures++;
                    $display("FAIL b2b_model dut%0d sample %0d got m=%0b cnt=%0d want %0b/%0d",
                             ids[j], i, m[ids[j]], cnt_o[ids[j]], mmatch[ids[j]], mcnt[ids[j]]);
                end
            end
        end
        step(0, 0, 1);
        for (int i = 0; i < 24; i++) begin
            step(1, seq[i], 0);
            for (int j = 0; j < 2; j++) begin
                checks++;
                if (m[ids[j]] !== tm[j][i] || cnt_o[ids[j]] !== tc[j][i]) begin
                    failures++;
                    $display("FAIL gap_trace dut%0d sample %0d got m=%0b cnt=%0d want %0b/%0d",
                             ids[j], i, m[ids[j]], cnt_o[ids[j]], tm[j][i], tc[j][i]);
                end
            end
            for (int g = 0; g < 100; g++) begin
                step(0, 1'($urandom_range(0, 1)), 0);
                if (g == 0) begin
                    checks++;
                    if (m[0] !== 1'b0 || m[5] !== 1'b0) begin
                        failures++;
                        $display("FAIL gap_idle_match sample %0d got %0b/%0b want 0/0", i, m[0], m[5]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        bit en, d, clr;
        step(0, 0, 1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #2;
                for (int k = 0; k < NDUT; k++) begin
                    checks++;
                    if (m[k] !== 1'b0 || s[k] !== 1'b0 || cnt_o[k] !== 0 || fill_o[k] !== 0) begin
                        failures++;
                        $display("FAIL rand_reset dut%0d got m=%0b sat=%0b cnt=%0d fill=%0d want 0", k, m[k], s[k], cnt_o[k], fill_o[k]);
                    end
                end
                @(posedge clk); #1;
                rst_n = 1'b1;
            end
            en  = ($urandom_range(0, 3) != 0);
            d   = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 199) == 0);
            step(en, d, clr);
            for (int k = 0; k < NDUT; k++) begin
                checks++;
                if (m[k] !== mmatch[k] || cnt_o[k] !== mcnt[k] || fill_o[k] !== exp_fill(k) ||
                    s[k] !== (mcnt[k] == cmax(k))) begin
                    failures++;
                    $display("FAIL rand dut%0d cyc %0d got m=%0b cnt=%0d fill=%0d sat=%0b want %0b/%0d/%0d/%0b",
                             k, cyc, m[k], cnt_o[k], fill_o[k], s[k], mmatch[k], mcnt[k], exp_fill(k), mcnt[k] == cmax(k));
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_default_seq();
        test_overlap_101();
        test_nonoverlap_fill();
        test_saturate();
        test_reset_mid();
        test_gap_vs_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
